// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between the instruction-fetch
// port and the data port. Data requests normally win. A starvation counter
// caps how many data grants in a row can complete while a fetch is waiting.
// A grant lasts until the RAM reports ACCESS or the requester drops its
// request (abort). Every grant is followed by one IDLE cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; the only state in which arbitration happens
// IGNT  | instruction fetch owns the RAM until ACCESS or iREN drops
// DGNT  | data port owns the RAM until ACCESS or dREN|dWEN drops
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_scnt;
    logic       w_dreq;
    logic       w_access;

    assign w_dreq   = dREN | dWEN;
    // ERROR and BUSY both count as "not done"; the grant simply holds and retries.
    assign w_access = (ramstate == RAM_ACCESS);

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Starvation counter: counts data completions that left a fetch waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_scnt <= 4'd0;
        end else if (w_access && (r_state == IGNT)) begin
            r_scnt <= 4'd0;
        end else if (w_access && (r_state == DGNT)) begin
            if (!iREN) begin
                r_scnt <= 4'd0;
            end else if (r_scnt < LIMIT) begin
                r_scnt <= r_scnt + 4'd1;
            end
        end
    end

    // Next-state: arbitrate in IDLE, hold a grant until completion or abort.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_dreq && iREN && (r_scnt == LIMIT)) begin
                    w_next_state = IGNT;
                end else if (w_dreq) begin
                    w_next_state = DGNT;
                end else if (iREN) begin
                    w_next_state = IGNT;
                end
            end
            IGNT: begin
                if (w_access || !iREN) begin
                    w_next_state = IDLE;
                end
            end
            DGNT: begin
                if (w_access || !w_dreq) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // RAM drive and wait signals, combinational from state and inputs.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = iREN;
        dwait    = w_dreq;
        case (r_state)
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = iREN & ~w_access;
            end
            DGNT: begin
                // A simultaneous read+write request is treated as a write.
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = w_dreq & ~w_access;
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: directed scenarios followed by a randomized
// phase, all compared cycle by cycle against a behavioural model of the
// arbitration rules.
module tb_memory_arbiter;

    localparam int LIM = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the RAM (0 nobody, 1 fetch, 2 data) and how many data
    // completions have happened in a row while a fetch was waiting.
    int m_owner = 0;
    int m_scnt  = 0;
    bit m_idone = 1'b0;
    bit m_ddone = 1'b0;

    logic        g_ramREN;
    logic        g_ramWEN;
    logic [31:0] g_ramaddr;
    string       grants;

    memory_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    // Inputs are set just after a falling edge; this checks the cycle and
    // advances the model across the following rising edge.
    task automatic step(input string tag);
        logic [131:0] exp_v;
        logic [131:0] obs_v;
        logic         e_ren, e_wen, e_iw, e_dw;
        logic [31:0]  e_addr, e_store;
        bit           dreq, acc;
        int           nxt, nscnt;
        #1;
        if (!nRST) begin
            m_owner = 0;
            m_scnt  = 0;
        end
        dreq    = dREN | dWEN;
        acc     = (ramstate == 2'd2);
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_addr  = 32'd0;
        e_store = 32'd0;
        e_iw    = iREN;
        e_dw    = dreq;
        if (m_owner == 1) begin
            e_ren  = 1'b1;
            e_addr = iaddr;
            e_iw   = iREN & !acc;
        end else if (m_owner == 2) begin
            e_wen   = dWEN;
            e_ren   = dREN & !dWEN;
            e_addr  = daddr;
            e_store = dstore;
            e_dw    = dreq & !acc;
        end
        exp_v = {e_ren, e_wen, e_addr, e_store, e_iw, e_dw, ramload, ramload};
        obs_v = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL %s outputs observed=%h expected=%h", tag, obs_v, exp_v);
        end
        n_cmp++;
        assert (dut.r_scnt === 4'(m_scnt)) else begin
            n_err++;
            $error("FAIL %s scnt observed=%0d expected=%0d", tag, dut.r_scnt, m_scnt);
        end
        g_ramREN  = ramREN;
        g_ramWEN  = ramWEN;
        g_ramaddr = ramaddr;

        nxt     = m_owner;
        nscnt   = m_scnt;
        m_idone = 1'b0;
        m_ddone = 1'b0;
        if (m_owner == 0) begin
            if (dreq && iREN && m_scnt == LIM) nxt = 1;
            else if (dreq)                     nxt = 2;
            else if (iREN)                     nxt = 1;
        end else if (m_owner == 1) begin
            if (acc) begin
                nxt     = 0;
                nscnt   = 0;
                m_idone = nRST;
            end else if (!iREN) begin
                nxt = 0;
            end
        end else begin
            if (acc) begin
                nxt     = 0;
                nscnt   = iREN ? ((m_scnt + 1 > LIM) ? LIM : m_scnt + 1) : 0;
                m_ddone = nRST;
            end else if (!dreq) begin
                nxt = 0;
            end
        end
        @(posedge CLK);
        if (nRST) begin
            m_owner = nxt;
            m_scnt  = nscnt;
        end else begin
            m_owner = 0;
            m_scnt  = 0;
        end
        @(negedge CLK);
    endtask

    initial begin
        int k;
        int r;
        nRST     = 1'b0;
        iREN     = 1'b1;
        iaddr    = 32'h0000_0010;
        dREN     = 1'b1;
        dWEN     = 1'b0;
        daddr    = 32'h0000_0020;
        dstore   = 32'h1234_5678;
        ramload  = 32'hA5A5_0001;
        ramstate = 2'd2;
        @(negedge CLK);

        // Reset held with both requests and ACCESS on the RAM.
        step("reset_hold0");
        step("reset_hold1");
        nRST = 1'b1;
        step("reset_release_idle");
        step("reset_release_dgnt");
        dREN = 1'b0;
        step("post_reset_idle");
        step("post_reset_ignt");
        iREN = 1'b0;
        step("post_reset_quiet");

        // Single fetch with two BUSY cycles.
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd0; ramload = 32'h1111_1111;
        step("fetch_idle");
        ramstate = 2'd1;
        step("fetch_busy0");
        step("fetch_busy1");
        ramstate = 2'd2; ramload = 32'h8C01_0004;
        step("fetch_access");
        iREN = 1'b0; ramstate = 2'd0;
        step("fetch_done_idle");

        // Write wins against a simultaneous fetch.
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; dWEN = 1'b1;
        daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = 2'd2;
        step("wwin_idle");
        step("wwin_dgnt");
        dREN = 1'b0; dWEN = 1'b0;
        step("wwin_idle2");
        step("wwin_ignt");
        iREN = 1'b0;
        step("wwin_quiet");

        // Starvation: both held continuously with a zero-wait RAM.
        iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h200; ramstate = 2'd2;
        grants = "";
        for (int c = 0; c < 20; c++) begin
            step("starve");
            if (g_ramREN || g_ramWEN) grants = {grants, (g_ramaddr == 32'h40) ? "I" : "D"};
        end
        n_cmp++;
        assert (grants == "DDDDIDDDDI") else begin
            n_err++;
            $error("FAIL starve_order observed=%s expected=DDDDIDDDDI", grants);
        end
        dREN = 1'b0;
        step("starve_idle");
        iREN = 1'b0;
        step("starve_quiet");

        // Abort of a data grant, counter left at 1.
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h300; ramstate = 2'd2;
        step("abort_pre_idle");
        step("abort_pre_dgnt");
        ramstate = 2'd1;
        step("abort_idle");
        step("abort_dgnt_busy");
        dREN = 1'b0;
        step("abort_drop");
        step("abort_after_idle");
        ramstate = 2'd2;
        step("abort_ignt");
        iREN = 1'b0;
        step("abort_quiet");

        // ERROR retry on a fetch.
        iREN = 1'b1; iaddr = 32'h80; ramstate = 2'd0;
        step("err_idle");
        ramstate = 2'd3;
        step("err_retry0");
        step("err_retry1");
        ramstate = 2'd2; ramload = 32'hCAFE_F00D;
        step("err_access");
        iREN = 1'b0;
        step("err_quiet");

        // Reset mid-access, then re-arbitration.
        dREN = 1'b1; daddr = 32'h400; ramstate = 2'd1;
        step("midrst_idle");
        step("midrst_dgnt");
        nRST = 1'b0;
        step("midrst_in_reset");
        nRST = 1'b1;
        step("midrst_release");
        ramstate = 2'd2;
        step("midrst_dgnt2");
        dREN = 1'b0;
        step("midrst_quiet");

        // Randomized traffic honoring the requester hold rule.
        for (int c = 0; c < 1500; c++) begin
            if (!iREN || m_idone) begin
                iREN  = ($urandom_range(0, 2) != 0);
                iaddr = $urandom;
            end
            if (!(dREN || dWEN) || m_ddone) begin
                k      = $urandom_range(0, 4);
                dREN   = (k == 1 || k == 3);
                dWEN   = (k == 2 || k == 3);
                daddr  = $urandom;
                dstore = $urandom;
            end
            r = $urandom_range(0, 9);
            ramstate = (r < 4) ? 2'd2 : (r < 7) ? 2'd1 : (r < 9) ? 2'd3 : 2'd0;
            ramload  = $urandom;
            if (ramstate != 2'd2 && $urandom_range(0, 19) == 0) iREN = 1'b0;
            if (ramstate != 2'd2 && $urandom_range(0, 19) == 0) begin
                dREN = 1'b0;
                dWEN = 1'b0;
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter that shares one single-ported RAM between the pipeline's instruction-fetch port and data-memory port. It sits between the datapath/cache interface and the RAM model. It registers a grant per access and holds it until the RAM reports completion. Data accesses have priority, and a starvation counter bounds instruction-fetch delay. It drives the `ihit`/`dhit`-style wait signals that stall the pipeline.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while an instruction request waits; range 1–15.
- `CLK`  in  1  rising-edge clock.
- `nRST`  in  1  asynchronous active-low reset.
- `iREN`  in  1  instruction read request.
- `iaddr`  in  32  instruction word address.
- `iwait`  out  1  1 = instruction access not complete this cycle.
- `iload`  out  32  instruction read data.
- `dREN`  in  1  data read request.
- `dWEN`  in  1  data write request.
- `daddr`  in  32  data address.
- `dstore`  in  32  data write value.
- `dwait`  out  1  1 = data access not complete this cycle.
- `dload`  out  32  data read data.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

## Operation
- **States.** IDLE, IGNT, DGNT. The state and the 4-bit starvation counter `scnt` are registers; all outputs are combinational from state and inputs.
- **Data request.** `dreq = dREN | dWEN`. When both `dREN` and `dWEN` are set, the request is a write: `ramREN=0`, `ramWEN=1`.
- **IDLE arbitration.** This is the only place arbitration happens.
  - `dreq & iREN & scnt==STARVE_LIMIT` -> IGNT.
  - Otherwise `dreq` -> DGNT.
  - Otherwise `iREN` -> IGNT.
  - Otherwise stay in IDLE.
- **IDLE outputs.** RAM enables are 0, `ramaddr` and `ramstore` are 0, and both ports wait on their own request.
- **IGNT.**
  - Drive `ramREN=1`, `ramWEN=0`, `ramaddr=iaddr`, `ramstore=0`.
  - `iwait = ~(ramstate==ACCESS)`.
  - Go to IDLE when `ramstate==ACCESS`, or when `iREN` drops (abort).
- **DGNT.**
  - Drive `ramREN=dREN&~dWEN`, `ramWEN=dWEN`, `ramaddr=daddr`, `ramstore=dstore`.
  - `dwait = ~(ramstate==ACCESS)`.
  - Go to IDLE when `ramstate==ACCESS`, or when `dreq` drops (abort).
- **Wait signals.**
  - The non-granted port always waits: `iwait=iREN`, `dwait=dreq`.
  - A port with no request has wait = 0.
- **Read data.** `iload=ramload` and `dload=ramload` unconditionally; the value is meaningful only in the completing cycle.
- **ERROR.** `ramstate==ERROR` while granted is treated as not-done. The grant is held and the access retries until ACCESS.
- **Starvation counter.**
  - On each DGNT completion with `iREN` high, `scnt` increments, saturating at `STARVE_LIMIT`.
  - `scnt` clears on any IGNT completion, or on a DGNT completion with `iREN` low.
  - An abort leaves `scnt` unchanged.

## Timing
- **Reset.** `nRST` low asynchronously forces state to IDLE and `scnt` to 0. In reset:
  - `ramREN=0`, `ramWEN=0`, `ramaddr=0`, `ramstore=0`.
  - `iwait=iREN`, `dwait=dreq`, `iload=dload=ramload`.
- **Reset mid-access.** RAM enables drop in the same cycle; the interrupted requester keeps waiting and is re-arbitrated after reset.
- **Latency.**
  - Cycle 0: request visible in IDLE.
  - Cycle 1: RAM enables asserted.
  - Completion is in the first cycle `ramstate==ACCESS` during the grant; wait = 0 in that cycle only.
  - The next cycle is IDLE, so back-to-back accesses cost at least 2 cycles each.
  - With 0-wait RAM (ACCESS on first enabled cycle), throughput is one access per 2 cycles.
- **Requester rule.** Requesters hold request, address and store data stable until their wait is low. Changing `daddr` mid-grant retargets the RAM; the arbiter does not latch addresses.
- **Simultaneous events.**
  - A request change in a completion cycle does not extend the grant.
  - A new request in the completion cycle is arbitrated in the following IDLE cycle.

## Test plan
- **Reset.** Hold `nRST=0` with `iREN=1`, `dREN=1`, `ramstate=ACCESS` -> `ramREN=0`, `ramWEN=0`, `ramaddr=0`, `iwait=1`, `dwait=1`. Release -> DGNT next cycle, `ramaddr=daddr`.
- **Single fetch.** `iREN=1`, `iaddr=0x40`; RAM returns BUSY×2 then ACCESS with `ramload=0x8C010004` -> `ramREN=1`, `ramaddr=0x40` for 3 cycles. `iwait` is low only in the ACCESS cycle, with `iload=0x8C010004`. IDLE follows.
- **Write wins.** `iREN=1` and `dWEN=1`, `dREN=1`, `daddr=0x100`, `dstore=0xDEADBEEF` together, 0-wait RAM -> first grant is data with `ramWEN=1`, `ramREN=0`, `ramstore=0xDEADBEEF`. `iwait` stays 1 through it; fetch is granted afterwards.
- **Starvation.** `iREN` and `dREN` both held high continuously, `STARVE_LIMIT=4`, 0-wait RAM -> grant order D,D,D,D,I, repeating. `scnt` reads 4 when the I grant is issued and 0 after it completes.
- **Abort.** DGNT with `ramstate=BUSY`, then `dREN` drops -> the same cycle shows `ramREN=0` and `dwait=0`. State is IDLE next cycle and `scnt` is unchanged.
- **Error retry.** IGNT, then `ramstate` ERROR×2 then ACCESS -> `ramaddr` is held and `iwait=1` during ERROR. Completion comes on ACCESS with no re-arbitration in between.
